// File: rtl/jtag_vpi_driver.sv
// JTAG bit-bang driver: shifts TAP_RESET/TMS_SEQ/SCAN/NOP commands out on tck/tms/tdi.
// Define JTAG_VPI_TDO_CAPTURE_EN to capture tdo into rsp_data; otherwise rsp_data stays 0.
module jtag_vpi_driver #(
    parameter int TCK_DIV = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        init_done,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [5:0]  cmd_len,
    input  logic [31:0] cmd_data,
    input  logic        cmd_exit,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        busy,
    output logic        tck,
    output logic        tms,
    output logic        tdi,
    input  logic        tdo
);

    localparam logic [1:0] OP_TAP_RESET = 2'd0;
    localparam logic [1:0] OP_TMS_SEQ   = 2'd1;
    localparam logic [1:0] OP_SCAN      = 2'd2;
    localparam logic [1:0] OP_NOP       = 2'd3;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOW  = 2'd1;
    localparam logic [1:0] S_HIGH = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [7:0] DIV_LAST = 8'(TCK_DIV - 1);

    logic [1:0]  state;
    logic [7:0]  div_cnt;
    logic [4:0]  bit_idx;
    logic [4:0]  last_idx;
    logic [1:0]  op_q;
    logic [31:0] data_q;
    logic        exit_q;
    logic        tms_q;
    logic        tdi_q;
    logic        accept;
    logic [4:0]  accept_last;
    logic        half_done;

    // Pin values {tms, tdi} for bit idx of a command.
    function automatic logic [1:0] bit_pins(input logic [1:0] op, input logic [31:0] data,
                                            input logic ex, input logic [4:0] idx,
                                            input logic [4:0] last);
        logic [1:0] pins;
        case (op)
            OP_TMS_SEQ: pins = {data[idx], 1'b0};
            OP_SCAN:    pins = {(idx == last) ? ex : 1'b0, data[idx]};
            default:    pins = 2'b10;
        endcase
        return pins;
    endfunction

    assign busy      = (state != S_IDLE);
    assign cmd_ready = enable & init_done & ~busy & ~rst;
    assign accept    = cmd_valid & cmd_ready;
    assign tck       = (state == S_HIGH);
    assign rsp_valid = (state == S_DONE);
    assign tms       = tms_q;
    assign tdi       = tdi_q;
    assign half_done = (div_cnt == DIV_LAST);

    // TAP_RESET always clocks 8 bits; a length of 0 (or anything past 32) means 32.
    always_comb begin
        accept_last = 5'd31;
        if (cmd_op == OP_TAP_RESET)
            accept_last = 5'd7;
        else if (cmd_len != 6'd0 && cmd_len <= 6'd32)
            accept_last = 5'(cmd_len - 6'd1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            div_cnt  <= '0;
            bit_idx  <= '0;
            last_idx <= '0;
            op_q     <= OP_NOP;
            data_q   <= '0;
            exit_q   <= 1'b0;
            tms_q    <= 1'b1;
            tdi_q    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_q     <= cmd_op;
                        data_q   <= cmd_data;
                        exit_q   <= cmd_exit;
                        last_idx <= accept_last;
                        bit_idx  <= '0;
                        div_cnt  <= '0;
                        if (cmd_op == OP_NOP) begin
                            state <= S_DONE;
                        end else begin
                            state          <= S_LOW;
                            {tms_q, tdi_q} <= bit_pins(cmd_op, cmd_data, cmd_exit, 5'd0, accept_last);
                        end
                    end
                end
                S_LOW: begin
                    div_cnt <= half_done ? 8'd0 : div_cnt + 8'd1;
                    if (half_done)
                        state <= S_HIGH;
                end
                S_HIGH: begin
                    div_cnt <= half_done ? 8'd0 : div_cnt + 8'd1;
                    if (half_done) begin
                        if (bit_idx == last_idx) begin
                            state <= S_DONE;
                        end else begin
                            state          <= S_LOW;
                            bit_idx        <= bit_idx + 5'd1;
                            {tms_q, tdi_q} <= bit_pins(op_q, data_q, exit_q, bit_idx + 5'd1, last_idx);
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef JTAG_VPI_TDO_CAPTURE_EN
    logic [31:0] cap_q;
    logic [31:0] rsp_data_q;

    // tdo is sampled on the edge that raises tck; the result is published on entry to DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            cap_q      <= '0;
            rsp_data_q <= '0;
        end else begin
            if (state == S_IDLE && accept) begin
                cap_q <= '0;
                if (cmd_op == OP_NOP)
                    rsp_data_q <= '0;
            end
            if (state == S_LOW && half_done)
                cap_q[bit_idx] <= tdo;
            if (state == S_HIGH && half_done && bit_idx == last_idx)
                rsp_data_q <= (op_q == OP_SCAN) ? cap_q : 32'd0;
        end
    end

    assign rsp_data = rsp_data_q;
`else
    logic unused_tdo;
    assign unused_tdo = tdo;
    assign rsp_data   = '0;
`endif

endmodule

// File: tb/tb_jtag_vpi_driver.sv
// Directed scoreboard bench for jtag_vpi_driver (TCK_DIV=2); follows JTAG_VPI_TDO_CAPTURE_EN.
module tb_jtag_vpi_driver;

    localparam int TCK_DIV = 2;
`ifdef JTAG_VPI_TDO_CAPTURE_EN
    localparam bit CAPTURE = 1'b1;
`else
    localparam bit CAPTURE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        init_done;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [5:0]  cmd_len;
    logic [31:0] cmd_data;
    logic        cmd_exit;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        busy;
    logic        tck;
    logic        tms;
    logic        tdi;
    logic        tdo;
    logic        tdo_loop;
    logic        tdo_const;

    int          compared   = 0;
    int          mismatched = 0;
    logic [31:0] exp_data_q[$];
    int          exp_lat_q[$];
    int          pulse_cnt  = 0;
    int          cmd_base   = 0;
    logic        tms_hist[1024];
    logic        tdi_hist[1024];

    jtag_vpi_driver #(.TCK_DIV(TCK_DIV)) dut (
        .clk(clk), .rst(rst), .enable(enable), .init_done(init_done),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_len(cmd_len), .cmd_data(cmd_data), .cmd_exit(cmd_exit),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
        .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo)
    );

    assign tdo = tdo_loop ? tdi : tdo_const;

    always #5 clk = ~clk;

    // Record the pin values seen by the target at every rising tck.
    always @(posedge tck) begin
        tms_hist[pulse_cnt % 1024] <= tms;
        tdi_hist[pulse_cnt % 1024] <= tdi;
        pulse_cnt                  <= pulse_cnt + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Called at a negedge; returns at the negedge following the accept edge.
    task automatic applyStimulus(input logic [1:0] op, input logic [5:0] len, input logic [31:0] data,
                                 input logic ex, input logic [31:0] exp_data, input int exp_lat);
        int w;
        cmd_op    = op;
        cmd_len   = len;
        cmd_data  = data;
        cmd_exit  = ex;
        cmd_valid = 1'b1;
        w = 0;
        while (!cmd_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        checkOutput("accept_ready", 32'(cmd_ready), 32'd1);
        cmd_base = pulse_cnt;
        @(posedge clk);
        exp_data_q.push_back(exp_data);
        exp_lat_q.push_back(exp_lat);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op    = 2'($urandom);
        cmd_len   = 6'($urandom);
        cmd_data  = $urandom;
        cmd_exit  = 1'($urandom);
    endtask

    task automatic awaitResponse(input string tag);
        int          k;
        logic [31:0] ed;
        int          el;
        k = 0;
        while (!rsp_valid && k < 400) begin
            @(negedge clk);
            k++;
        end
        checkOutput({tag, "_valid"}, 32'(rsp_valid), 32'd1);
        ed = exp_data_q.pop_front();
        el = exp_lat_q.pop_front();
        checkOutput({tag, "_latency"}, 32'(k + 1), 32'(el));
        checkOutput({tag, "_data"}, rsp_data, ed);
        checkOutput({tag, "_tck_done"}, 32'(tck), 32'd0);
        @(negedge clk);
        checkOutput({tag, "_valid_pulse"}, 32'(rsp_valid), 32'd0);
        checkOutput({tag, "_busy_clr"}, 32'(busy), 32'd0);
    endtask

    task automatic checkPins(input string tag, input int n_exp, input logic [31:0] tms_exp,
                             input logic [31:0] tdi_exp);
        int          n;
        logic [31:0] ts;
        logic [31:0] ds;
        n  = pulse_cnt - cmd_base;
        ts = '0;
        ds = '0;
        for (int i = 0; i < n && i < 32; i++) begin
            ts[i] = tms_hist[(cmd_base + i) % 1024];
            ds[i] = tdi_hist[(cmd_base + i) % 1024];
        end
        checkOutput({tag, "_pulses"}, 32'(n), 32'(n_exp));
        checkOutput({tag, "_tms_seq"}, ts, tms_exp);
        checkOutput({tag, "_tdi_seq"}, ds, tdi_exp);
    endtask

    initial begin
        int seen;
        rst       = 1'b1;
        enable    = 1'b1;
        init_done = 1'b1;
        cmd_valid = 1'b1;
        cmd_op    = 2'd2;
        cmd_len   = 6'd8;
        cmd_data  = 32'h0;
        cmd_exit  = 1'b0;
        tdo_loop  = 1'b0;
        tdo_const = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("ready_in_rst", 32'(cmd_ready), 32'd0);
        cmd_valid = 1'b0;
        rst       = 1'b0;
        @(negedge clk);
        checkOutput("rst_tck", 32'(tck), 32'd0);
        checkOutput("rst_tms", 32'(tms), 32'd1);
        checkOutput("rst_tdi", 32'(tdi), 32'd0);
        checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("rst_rsp_data", rsp_data, 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("idle_ready", 32'(cmd_ready), 32'd1);

        $display("[TB] TAP_RESET");
        applyStimulus(2'd0, 6'd3, 32'h1234_5678, 1'b0, 32'd0, 33);
        awaitResponse("tap_reset");
        checkPins("tap_reset", 8, 32'h0000_00FF, 32'h0);

        $display("[TB] SCAN 0xA5 looped");
        tdo_loop = 1'b1;
        applyStimulus(2'd2, 6'd8, 32'h0000_00A5, 1'b1, CAPTURE ? 32'h0000_00A5 : 32'd0, 33);
        awaitResponse("scan_a5");
        checkPins("scan_a5", 8, 32'h0000_0080, 32'h0000_00A5);
        checkOutput("scan_a5_idle_tms", 32'(tms), 32'd1);
        checkOutput("scan_a5_idle_tdi", 32'(tdi), 32'd1);
        tdo_loop = 1'b0;

        $display("[TB] SCAN len 0");
        applyStimulus(2'd2, 6'd0, 32'hFFFF_FFFF, 1'b0, 32'd0, 129);
        awaitResponse("scan32");
        checkPins("scan32", 32, 32'h0, 32'hFFFF_FFFF);

        $display("[TB] TMS_SEQ");
        applyStimulus(2'd1, 6'd5, 32'hABCD_EF16, 1'b0, 32'd0, 21);
        awaitResponse("tms_seq");
        checkPins("tms_seq", 5, 32'h0000_0016, 32'h0);
        checkOutput("tms_seq_idle_tms", 32'(tms), 32'd1);
        checkOutput("tms_seq_idle_tck", 32'(tck), 32'd0);

        $display("[TB] SCAN len 4 with tdo high");
        tdo_const = 1'b1;
        applyStimulus(2'd2, 6'd4, 32'h0, 1'b0, CAPTURE ? 32'h0000_000F : 32'd0, 17);
        awaitResponse("scan4");
        checkPins("scan4", 4, 32'h0, 32'h0);
        repeat (3) @(negedge clk);
        checkOutput("scan4_hold", rsp_data, CAPTURE ? 32'h0000_000F : 32'd0);
        tdo_const = 1'b0;

        $display("[TB] NOP");
        applyStimulus(2'd3, 6'd9, 32'hFFFF_FFFF, 1'b1, 32'd0, 1);
        awaitResponse("nop");
        checkPins("nop", 0, 32'h0, 32'h0);

        $display("[TB] enable gating");
        enable    = 1'b0;
        tdo_loop  = 1'b1;
        cmd_op    = 2'd2;
        cmd_len   = 6'd8;
        cmd_data  = 32'h0000_003C;
        cmd_exit  = 1'b0;
        cmd_valid = 1'b1;
        cmd_base  = pulse_cnt;
        repeat (5) @(negedge clk);
        checkOutput("gated_ready", 32'(cmd_ready), 32'd0);
        checkOutput("gated_busy", 32'(busy), 32'd0);
        checkOutput("gated_pulses", 32'(pulse_cnt - cmd_base), 32'd0);
        enable = 1'b1;
        #1;
        checkOutput("enable_ready", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        exp_data_q.push_back(CAPTURE ? 32'h0000_003C : 32'd0);
        exp_lat_q.push_back(33);
        @(negedge clk);
        cmd_valid = 1'b0;
        enable    = 1'b0;
        init_done = 1'b0;
        awaitResponse("enable_drop");
        checkPins("enable_drop", 8, 32'h0, 32'h0000_003C);
        enable    = 1'b1;
        init_done = 1'b1;
        tdo_loop  = 1'b0;
        @(negedge clk);
        checkOutput("reenable_ready", 32'(cmd_ready), 32'd1);

        $display("[TB] reset mid-SCAN");
        applyStimulus(2'd2, 6'd16, 32'h0000_BEEF, 1'b1, 32'd0, 65);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("abort_tck", 32'(tck), 32'd0);
        checkOutput("abort_tms", 32'(tms), 32'd1);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_valid", 32'(rsp_valid), 32'd0);
        checkOutput("abort_data", rsp_data, 32'd0);
        rst = 1'b0;
        void'(exp_data_q.pop_front());
        void'(exp_lat_q.pop_front());
        seen = 0;
        repeat (100) begin
            @(negedge clk);
            if (rsp_valid)
                seen++;
        end
        checkOutput("abort_no_rsp", 32'(seen), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/jtag_vpi_driver.md
JTAG_VPI_DRIVER -- requirements
Module: jtag_vpi_driver

Interface
REQ-001 SHALL have parameter TCK_DIV, default 2, meaning clk cycles per TCK half-period (legal 1..255).
REQ-002 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port enable  input  1  driver enable; commands are accepted only when high.
REQ-005 SHALL have port init_done  input  1  target-ready flag; commands are accepted only when high.
REQ-006 SHALL have port cmd_valid  input  1  command request.
REQ-007 SHALL have port cmd_ready  output  1  command accept; transfer occurs when cmd_valid and cmd_ready are both high.
REQ-008 SHALL have port cmd_op  input  2  opcode: 0 TAP_RESET, 1 TMS_SEQ, 2 SCAN, 3 NOP.
REQ-009 SHALL have port cmd_len  input  6  bit count; 1..32, with 0 meaning 32.
REQ-010 SHALL have port cmd_data  input  32  bits to shift, LSB first.
REQ-011 SHALL have port cmd_exit  input  1  SCAN only: TMS value on the last bit.
REQ-012 SHALL have port rsp_valid  output  1  one-cycle completion pulse.
REQ-013 SHALL have port rsp_data  output  32  captured TDO, held until the next completion.
REQ-014 SHALL have port busy  output  1  high from accept until the rsp_valid cycle inclusive.
REQ-015 SHALL have ports tck, tms, tdi (output, 1 bit each) and tdo (input, 1 bit) as the JTAG pins.

Function
REQ-016 cmd_ready SHALL equal enable & init_done & ~busy.
REQ-017 The accepted op, length, data and exit values SHALL be latched; inputs are don't-care afterwards.
REQ-018 The FSM SHALL have states IDLE -> LOW -> HIGH -> (LOW for the next bit | DONE) -> IDLE.
REQ-019 Each bit SHALL spend TCK_DIV cycles in LOW (tck=0) followed by TCK_DIV cycles in HIGH (tck=1).
REQ-020 tms and tdi SHALL update on entry to LOW and remain stable through HIGH.
REQ-021 tdo SHALL be sampled on the clk edge where tck goes 0->1.
REQ-022 Bit i of a SCAN (i=0..len-1) SHALL be sampled into rsp_data[i]; bits len..31 SHALL be 0.
REQ-023 TAP_RESET SHALL drive 8 bits with tms=1 and tdi=0, ignoring len and data; rsp_data=0.
REQ-024 TMS_SEQ SHALL drive tms = data[i] with tdi=0; rsp_data=0.
REQ-025 SCAN SHALL drive tdi = data[i] and tms=0, except the last bit where tms = exit.
REQ-026 NOP SHALL go directly to DONE with no TCK activity; rsp_data=0.
REQ-027 Latency SHALL be rsp_valid high exactly 1 + N*2*TCK_DIV cycles after the accept edge, where N is the bit count (NOP: 1 cycle).
REQ-028 In DONE, rsp_valid SHALL be 1 for one cycle with tck=0; tms and tdi SHALL hold their last values; the FSM then returns to IDLE.
REQ-029 In IDLE, tck SHALL be 0 and tms/tdi SHALL hold their last values.
REQ-030 Deassertion of enable or init_done mid-command SHALL NOT abort the command; it blocks further accepts only.
REQ-031 A new command SHALL be accepted no earlier than the cycle after rsp_valid (no back-to-back overlap).

Reset
REQ-032 On rst, the FSM SHALL enter IDLE, aborting any command immediately.
REQ-033 Reset values SHALL be: tck=0, tms=1, tdi=0, rsp_valid=0, rsp_data=0, busy=0.
REQ-034 cmd_ready SHALL be 0 during the rst cycle.

Configuration
REQ-035 Macro JTAG_VPI_TDO_CAPTURE_EN defined: tdo capture SHALL operate per REQ-021/022.
REQ-036 Macro JTAG_VPI_TDO_CAPTURE_EN undefined: tdo SHALL be ignored, rsp_data SHALL always be 0, and timing SHALL be unchanged.

Verification
REQ-037 TCK_DIV=2: TAP_RESET -> 8 tck pulses with tms=1; rsp_valid 33 cycles after accept; rsp_data=0.
REQ-038 SCAN len=8, data=0xA5, exit=1, tdo looped to tdi -> tdi sequence 1,0,1,0,0,1,0,1; tms high only on bit 7; rsp_data=0x000000A5.
REQ-039 SCAN len=0, data=0xFFFFFFFF, tdo=0 -> 32 bits shifted, rsp_data=0, latency 129 cycles.
REQ-040 enable=0 with cmd_valid=1 -> cmd_ready=0 and no tck activity; raising enable -> accepted the same cycle.
REQ-041 rst asserted mid-SCAN -> next cycle tck=0, tms=1, busy=0, and no rsp_valid pulse.
REQ-042 Build without JTAG_VPI_TDO_CAPTURE_EN, repeat REQ-038 -> rsp_data=0 with identical timing.
